// File: rtl/sync_decoder.sv
// Recovers column/row counters from active-video h/v strobes, checks them
// against the nominal timing and reports lock status and timing errors.
module sync_decoder #(
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_h_sync,
  input  logic       i_v_sync,
  output logic       o_h_sync,
  output logic       o_v_sync,
  output logic [9:0] o_col_num,
  output logic [9:0] o_row_num,
  output logic       o_frame_start,
  output logic       o_locked,
  output logic       o_sync_err
);
  localparam logic [1:0] SEARCH = 2'd0;
  localparam logic [1:0] CHECK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [10:0] TC = 11'(TOTAL_COLS);
  localparam logic [10:0] TR = 11'(TOTAL_ROWS);
  localparam logic [10:0] AC = 11'(ACTIVE_COLS);
  localparam logic [10:0] AR = 11'(ACTIVE_ROWS);

  logic [1:0]  state, state_nx;
  logic        err, err_nx, sync_err_nx;
  logic        hr, hf, vr, vf;
  logic [10:0] meas_col, meas_row;
  logic        sat, h_viol, v_viol, frame_ok;

  assign hr = i_h_sync & ~o_h_sync;
  assign hf = ~i_h_sync & o_h_sync;
  assign vr = i_v_sync & ~o_v_sync;
  assign vf = ~i_v_sync & o_v_sync;

  assign meas_col = {1'b0, o_col_num} + 11'd1;
  assign meas_row = {1'b0, o_row_num} + 11'd1;

  // Flag only the step into saturation so a stuck line reports once.
  assign sat      = ~hr && (o_col_num == 10'd1022);
  assign h_viol   = (hr && meas_col != TC) || (hf && meas_col != AC) || sat;
  assign v_viol   = (vr && meas_row != TR) || (vf && meas_row != AR);
  assign frame_ok = (meas_row == TR);

  always_comb begin
    state_nx    = state;
    err_nx      = err;
    sync_err_nx = 1'b0;
    case (state)
      SEARCH: begin
        if (vr) begin
          state_nx = CHECK;
          err_nx   = 1'b0;
        end
      end
      CHECK: begin
        // A frame boundary closes one check window and opens the next.
        if (vr) begin
          if (!err && !h_viol && frame_ok) state_nx = LOCKED;
          err_nx = 1'b0;
        end else if (h_viol || v_viol) begin
          err_nx = 1'b1;
        end
      end
      LOCKED: begin
        if (h_viol || v_viol) begin
          state_nx    = SEARCH;
          sync_err_nx = 1'b1;
        end
      end
      default: state_nx = SEARCH;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_h_sync      <= 1'b0;
      o_v_sync      <= 1'b0;
      o_col_num     <= '0;
      o_row_num     <= '0;
      o_frame_start <= 1'b0;
      o_locked      <= 1'b0;
      o_sync_err    <= 1'b0;
      state         <= SEARCH;
      err           <= 1'b0;
    end else begin
      o_h_sync      <= i_h_sync;
      o_v_sync      <= i_v_sync;
      o_frame_start <= vr;
      o_locked      <= (state_nx == LOCKED);
      o_sync_err    <= sync_err_nx;
      state         <= state_nx;
      err           <= err_nx;
      if (hr)                          o_col_num <= '0;
      else if (o_col_num != 10'h3FF)   o_col_num <= o_col_num + 10'd1;
      if (vr)                          o_row_num <= '0;
      else if (hr && o_row_num != 10'h3FF) o_row_num <= o_row_num + 10'd1;
    end
  end
endmodule

// File: tb/tb_sync_decoder.sv
// Directed bench: small-timing instance for lock/error behaviour, default
// instance for an off-nominal 801-cycle source.
module tb_sync_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic h = 1'b0, v = 1'b0, h2 = 1'b0, v2 = 1'b0;
  logic o_h, o_v, fs, lk, se;
  logic [9:0] col, row;
  logic o_h2, o_v2, fs2, lk2, se2;
  logic [9:0] col2, row2;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_decoder #(.TOTAL_COLS(10), .TOTAL_ROWS(6), .ACTIVE_COLS(8), .ACTIVE_ROWS(4)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_h_sync(h), .i_v_sync(v),
    .o_h_sync(o_h), .o_v_sync(o_v), .o_col_num(col), .o_row_num(row),
    .o_frame_start(fs), .o_locked(lk), .o_sync_err(se));

  sync_decoder dut_def (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_h_sync(h2), .i_v_sync(v2),
    .o_h_sync(o_h2), .o_v_sync(o_v2), .o_col_num(col2), .o_row_num(row2),
    .o_frame_start(fs2), .o_locked(lk2), .o_sync_err(se2));

  logic [24:0] obs, exp_v;
  int  f_errs, f_err_y, f_err_x;
  logic f_err_lk, f_lk_end;

  task automatic cyc(input logic hh, input logic vv);
    h = hh; v = vv;
    @(posedge clk); #1;
  endtask

  // One 6-line frame; vact lines with v high, line `stretch` is 11 cycles.
  task automatic frame(input int vact, input int stretch);
    f_errs = 0; f_err_y = -1; f_err_x = -1; f_err_lk = 1'bx;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < ((y == stretch) ? 11 : 10); x++) begin
        cyc(x < 8, y < vact);
        if (se) begin
          if (f_errs == 0) begin f_err_y = y; f_err_x = x; f_err_lk = lk; end
          f_errs++;
        end
      end
    end
    f_lk_end = lk;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; h = 1'b1; v = 1'b1; h2 = 1'b1; v2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({o_h, o_v, col, row, fs, lk, se} !== 25'd0) begin
      fails++; $display("FAIL reset_small: got %h expected 0", {o_h, o_v, col, row, fs, lk, se});
    end
    tests++;
    if ({o_h2, o_v2, col2, row2, fs2, lk2, se2} !== 25'd0) begin
      fails++; $display("FAIL reset_default: got %h expected 0", {o_h2, o_v2, col2, row2, fs2, lk2, se2});
    end
    h2 = 1'b0; v2 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_clean_lock();
    for (int f = 0; f < 2; f++)
      for (int y = 0; y < 6; y++)
        for (int x = 0; x < 10; x++) begin
          cyc(x < 8, y < 4);
          obs   = {o_h, o_v, col, row, fs, lk, se};
          exp_v = {x < 8, y < 4, 10'(x), 10'(y), (x == 0 && y == 0), f == 1, 1'b0};
          tests++;
          if (obs !== exp_v) begin
            fails++;
            $display("FAIL clean f%0d y%0d x%0d: got %h expected %h", f, y, x, obs, exp_v);
          end
        end
  endtask

  task automatic test_stretch();
    frame(4, 1);
    tests++;
    if ({f_errs, f_err_y, f_err_x, f_err_lk, f_lk_end} !== {32'd1, 32'd2, 32'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL stretch_err: errs %0d at y%0d x%0d lk %b end_lk %b expected 1 at y2 x0 lk 0 end_lk 0",
               f_errs, f_err_y, f_err_x, f_err_lk, f_lk_end);
    end
    frame(4, -1);
    tests++;
    if (f_lk_end !== 1'b0) begin fails++; $display("FAIL stretch_relock1: lk %b expected 0", f_lk_end); end
    frame(4, -1);
    tests++;
    if ({f_lk_end, f_errs} !== {1'b1, 32'd0}) begin
      fails++; $display("FAIL stretch_relock2: lk %b errs %0d expected lk 1 errs 0", f_lk_end, f_errs);
    end
  endtask

  task automatic test_saturate();
    int n_err;
    logic [9:0] col_at_err;
    n_err = 0; col_at_err = '0;
    for (int x = 0; x < 10; x++) cyc(x < 8, 1'b1);
    for (int x = 0; x < 8; x++) cyc(1'b1, 1'b1);
    for (int i = 0; i < 1100; i++) begin
      cyc(1'b0, 1'b1);
      if (se) begin n_err++; col_at_err = col; end
    end
    tests++;
    if (n_err !== 1) begin fails++; $display("FAIL sat_err_count: got %0d expected 1", n_err); end
    tests++;
    if (col_at_err !== 10'd1023) begin fails++; $display("FAIL sat_err_col: got %0d expected 1023", col_at_err); end
    tests++;
    if ({col, lk} !== {10'd1023, 1'b0}) begin
      fails++; $display("FAIL sat_hold: col %0d lk %b expected col 1023 lk 0", col, lk);
    end
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    frame(4, -1);
    frame(4, -1);
    tests++;
    if (f_lk_end !== 1'b1) begin fails++; $display("FAIL sat_relock: lk %b expected 1", f_lk_end); end
  endtask

  task automatic test_vheight();
    frame(5, -1);
    tests++;
    if ({f_errs, f_err_y, f_err_x, f_lk_end} !== {32'd1, 32'd5, 32'd0, 1'b0}) begin
      fails++;
      $display("FAIL vheight_err: errs %0d at y%0d x%0d end_lk %b expected 1 at y5 x0 end_lk 0",
               f_errs, f_err_y, f_err_x, f_lk_end);
    end
    frame(4, -1);
    frame(4, -1);
    tests++;
    if (f_lk_end !== 1'b1) begin fails++; $display("FAIL vheight_relock: lk %b expected 1", f_lk_end); end
  endtask

  task automatic test_reset_mid();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 10; x++) cyc(x < 8, 1'b1);
    for (int x = 0; x < 9; x++) cyc(x < 8, 1'b0);
    tests++;
    if (lk !== 1'b1) begin fails++; $display("FAIL rstmid_prelock: lk %b expected 1", lk); end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({o_h, o_v, col, row, fs, lk, se} !== 25'd0) begin
      fails++; $display("FAIL rstmid_async: got %h expected 0", {o_h, o_v, col, row, fs, lk, se});
    end
    @(posedge clk); #1 rst_n = 1'b1;
    cyc(1'b0, 1'b0);
    tests++;
    if ({o_h, o_v, col, row, fs, lk, se} !== {1'b0, 1'b0, 10'd1, 10'd0, 3'b000}) begin
      fails++; $display("FAIL rstmid_count: got %h expected col 1 rest 0", {o_h, o_v, col, row, fs, lk, se});
    end
    cyc(1'b1, 1'b0);
    tests++;
    if ({o_h, o_v, col, row, fs, lk, se} !== {1'b1, 1'b0, 10'd0, 10'd1, 3'b000}) begin
      fails++; $display("FAIL rstmid_hr: got %h expected h 1 col 0 row 1", {o_h, o_v, col, row, fs, lk, se});
    end
    for (int x = 1; x < 10; x++) cyc(x < 8, 1'b0);
    frame(4, -1);
    tests++;
    if (f_lk_end !== 1'b0) begin fails++; $display("FAIL rstmid_vr1: lk %b expected 0", f_lk_end); end
    frame(4, -1);
    tests++;
    if (f_lk_end !== 1'b1) begin fails++; $display("FAIL rstmid_vr2: lk %b expected 1", f_lk_end); end
  endtask

  task automatic test_defaults();
    int max_col;
    logic lk_seen, se_seen;
    logic [9:0] col_end;
    max_col = 0; lk_seen = 1'b0; se_seen = 1'b0; col_end = '0;
    h = 1'b0; v = 1'b0;
    for (int ln = 0; ln < 9; ln++)
      for (int x = 0; x < 801; x++) begin
        h2 = (x < 640); v2 = ((ln % 3) < 2);
        @(posedge clk); #1;
        if (int'(col2) > max_col) max_col = int'(col2);
        if (lk2) lk_seen = 1'b1;
        if (se2) se_seen = 1'b1;
        if (ln == 4 && x == 800) col_end = col2;
      end
    tests++;
    if (col_end !== 10'd800) begin fails++; $display("FAIL def_col_end: got %0d expected 800", col_end); end
    tests++;
    if (max_col != 800) begin fails++; $display("FAIL def_col_max: got %0d expected 800", max_col); end
    tests++;
    if ({lk_seen, se_seen} !== 2'b00) begin
      fails++; $display("FAIL def_nolock: lk_seen %b se_seen %b expected 0 0", lk_seen, se_seen);
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_stretch();
    test_saturate();
    test_vheight();
    test_reset_mid();
    test_defaults();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sync_decoder.md
# sync_decoder

Receive-side counterpart of the VGA sync generator. Takes the active-high active-video strobes `i_h_sync`/`i_v_sync` and recovers registered column/row counters aligned to them. It also checks the stream against the nominal timing parameters and reports lock status. It sits between any sync source and downstream pixel logic (ball/paddle drawing, pattern generators) so that logic can work from counts instead of raw strobes.

## Interface
- `TOTAL_COLS`, 800: required cycles between successive `i_h_sync` rising edges.
- `TOTAL_ROWS`, 525: required `i_h_sync` rising edges per `i_v_sync` period.
- `ACTIVE_COLS`, 640: required `i_h_sync` high time, in cycles.
- `ACTIVE_ROWS`, 480: required `i_v_sync` high time, in lines.
- `i_Clk` input 1: pixel clock; all state on rising edge.
- `i_Rst_n` input 1: asynchronous, active-low reset.
- `i_h_sync` input 1: high during active columns.
- `i_v_sync` input 1: high during active rows.
- `o_h_sync` output 1: `i_h_sync` delayed one cycle.
- `o_v_sync` output 1: `i_v_sync` delayed one cycle.
- `o_col_num` output 10: column count aligned to `o_h_sync`.
- `o_row_num` output 10: row count aligned to `o_v_sync`.
- `o_frame_start` output 1: one-cycle pulse, first cycle of a frame.
- `o_locked` output 1: stream matches parameters.
- `o_sync_err` output 1: one-cycle pulse on any timing violation while locked.

## Operation
- Edge terms (combinational, input vs. delayed copy):
  - hr = `i_h_sync & ~o_h_sync`
  - hf = `~i_h_sync & o_h_sync`
  - vr = `i_v_sync & ~o_v_sync`
  - vf = `~i_v_sync & o_v_sync`
- Column counter: hr → 0; else +1, saturating at 1023.
- Row counter:
  - vr → 0, with priority over hr.
  - Else hr → +1, saturating at 1023.
  - Else hold.
- Measurements use 11-bit compares:
  - line length L = `o_col_num`+1, evaluated at hr.
  - active width W = `o_col_num`+1, evaluated at hf.
  - frame height F = `o_row_num`+1, evaluated at vr.
  - active height H = `o_row_num`+1, evaluated at vf.
- A violation is any of:
  - hr with L≠TOTAL_COLS
  - hf with W≠ACTIVE_COLS
  - vr with F≠TOTAL_ROWS
  - vf with H≠ACTIVE_ROWS
  - `o_col_num` reaching 1023, i.e. no horizontal edge
- Lock FSM (2-bit):
  - SEARCH: on vr → CHECK and clear sticky err.
  - CHECK: a violation sets err, except the hr and vr checks in the same cycle as the vr that entered CHECK (that line and frame straddle the acquisition point). On a later vr: if err=0 and F=TOTAL_ROWS → LOCKED; else stay in CHECK and clear err. If F≠TOTAL_ROWS, err is not set.
  - LOCKED: a violation → SEARCH and pulse `o_sync_err`.
- `o_locked` = (state==LOCKED), registered.
- `o_frame_start` is registered from vr: high in the cycle `o_row_num` first reads 0. It fires in every state.

## Timing
- Reset (asynchronous assert, synchronous deassert by the environment): all outputs 0, state SEARCH, err 0.
- Latency: one cycle from input to `o_h_sync`/`o_v_sync`. Counters, `o_frame_start`, `o_locked` and `o_sync_err` change on the same edge as the delayed syncs.
  - `o_col_num`=0 in the first cycle `o_h_sync`=1.
  - `o_row_num`=0 and `o_frame_start`=1 in the first cycle `o_v_sync`=1.
- Lock time: `o_locked` rises on the clock edge of the second vr after reset, given a clean stream.
- Unlock: `o_locked` falls on the edge that registers the violating edge, in the same cycle as `o_sync_err`. Re-lock again needs two vr events.
- vr without hr: row → 0, column keeps counting. The next hr is checked normally.
- Saturation: counters stick at 1023. In LOCKED, the saturation violation fires exactly once (entry into SEARCH). Counting resumes at the next edge.
- Reset mid-frame: counters restart from 0 and increment until the next edge. There is no lock until two vr events.

## Test plan
Run with TOTAL_COLS=10, TOTAL_ROWS=6, ACTIVE_COLS=8, ACTIVE_ROWS=4 unless stated.
- Clean stream from reset → first vr gives `o_frame_start` and row 0. `o_col_num` cycles 0..9 with `o_h_sync`=1 exactly for cols 0..7. `o_row_num` cycles 0..5. `o_locked`=1 on the edge of the 2nd vr.
- Locked, then one line stretched to 11 cycles → `o_sync_err`=1 for one cycle and `o_locked`→0 at the hr ending that line. Re-lock occurs at the 2nd subsequent vr.
- Locked, then `i_h_sync` held low → `o_col_num` saturates at 1023 and holds. A single `o_sync_err` pulse fires when it reaches 1023.
- Active-height error: `i_v_sync` high for 5 lines while locked → error at vf, `o_locked`=0.
- `i_Rst_n` pulsed low mid-line for 1 cycle → all outputs 0 immediately, asynchronously. Counts resume from 0, and `o_locked` stays 0 until the 2nd vr.
- Defaults (800/525/640/480), source with 801-cycle lines → never locks. Counts still track: `o_col_num` reaches 800.
